// File: rtl/dma_stream_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_stream_engine_if
// Brief    : Arbiter read/write ports plus the two accelerator AXI-Stream links
//            of the DMA stream engine, with engine (master) and peer (slave) views.
// Revision : 1.0 - initial release
// ============================================================================
interface dma_stream_engine_if #(
    parameter int ADDR_W = 13
);
    logic              dma_r_ready;
    logic [ADDR_W-1:0] dma_r_addr;
    logic              dma_r_ack;
    logic [31:0]       dma_r_data;
    logic              dma_r_data_valid;
    logic              dma_w_valid;
    logic [ADDR_W-1:0] dma_w_addr;
    logic [31:0]       dma_w_data;
    logic              sm_tvalid;
    logic              sm_tready;
    logic [31:0]       sm_tdata;
    logic              sm_tlast;
    logic              ss_tvalid;
    logic              ss_tready;
    logic [31:0]       ss_tdata;
    logic              ss_tlast;

    modport master (
        output dma_r_ready, dma_r_addr,
        input  dma_r_ack, dma_r_data, dma_r_data_valid,
        output dma_w_valid, dma_w_addr, dma_w_data,
        output sm_tvalid, sm_tdata, sm_tlast,
        input  sm_tready,
        input  ss_tvalid, ss_tdata, ss_tlast,
        output ss_tready
    );

    modport slave (
        input  dma_r_ready, dma_r_addr,
        output dma_r_ack, dma_r_data, dma_r_data_valid,
        input  dma_w_valid, dma_w_addr, dma_w_data,
        input  sm_tvalid, sm_tdata, sm_tlast,
        output sm_tready,
        output ss_tvalid, ss_tdata, ss_tlast,
        input  ss_tready
    );
endinterface
`default_nettype wire

// File: rtl/dma_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : dma_stream_engine
// Brief    : DMA initiator: reads a block from BRAM u0 into an AXI-Stream master,
//            writes the returning AXI-Stream slave data into BRAM u1.
//            Optional cycle counter output enabled by `DMA_STREAM_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dma_stream_engine #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 13
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_src_addr,
    input  logic [ADDR_W-1:0] cfg_dst_addr,
    input  logic [ADDR_W-1:0] cfg_len,
    output logic              busy,
    output logic              done,
    output logic              err_tlast,
`ifdef DMA_STREAM_PERF_EN
    output logic [31:0]       perf_cycles,
`endif
    dma_stream_engine_if.master bus
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [ADDR_W-1:0]   r_src;
    logic [ADDR_W-1:0]   r_dst;
    logic [ADDR_W-1:0]   r_len;
    logic [ADDR_W-1:0]   r_rd_cnt;
    logic [ADDR_W-1:0]   r_out_cnt;
    logic [ADDR_W-1:0]   r_wr_cnt;
    logic [c_cnt_w-1:0]  r_outstanding;
    logic [c_cnt_w-1:0]  r_fifo_count;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [31:0]         r_mem [FIFO_DEPTH];
    logic                r_w_valid;
    logic [ADDR_W-1:0]   r_w_addr;
    logic [31:0]         r_w_data;
`ifdef DMA_STREAM_PERF_EN
    logic [31:0]         r_perf;
`endif

    logic                w_run;
    logic                w_credit;
    logic                w_rd_req;
    logic                w_rd_fire;
    logic                w_push;
    logic                w_pop;
    logic                w_fifo_nempty;
    logic                w_ss_ready;
    logic                w_ss_fire;
    logic [ADDR_W-1:0]   w_len_m1;

    assign w_run         = (r_state == S_RUN);
    // Words already requested plus words buffered may never exceed the FIFO size,
    // so every return always finds a free slot.
    assign w_credit      = ({1'b0, r_outstanding} + {1'b0, r_fifo_count}) < c_depth;
    assign w_rd_req      = w_run && (r_rd_cnt < r_len) && w_credit;
    assign w_rd_fire     = w_rd_req && bus.dma_r_ack;
    assign w_push        = bus.dma_r_data_valid && (r_outstanding != '0);
    assign w_fifo_nempty = (r_fifo_count != '0);
    assign w_pop         = w_fifo_nempty && bus.sm_tready;
    assign w_ss_ready    = w_run && (r_wr_cnt < r_len);
    assign w_ss_fire     = bus.ss_tvalid && w_ss_ready;
    assign w_len_m1      = r_len - 1'b1;

    assign bus.dma_r_ready = w_rd_req;
    assign bus.dma_r_addr  = r_src + r_rd_cnt;
    assign bus.dma_w_valid = r_w_valid;
    assign bus.dma_w_addr  = r_w_addr;
    assign bus.dma_w_data  = r_w_data;
    assign bus.sm_tvalid   = w_fifo_nempty;
    assign bus.sm_tdata    = w_fifo_nempty ? r_mem[r_rd_ptr] : 32'd0;
    assign bus.sm_tlast    = w_run && (r_out_cnt == w_len_m1);
    assign bus.ss_tready   = w_ss_ready;

    assign busy      = r_busy;
    assign done      = r_done;
    assign err_tlast = r_err;
`ifdef DMA_STREAM_PERF_EN
    assign perf_cycles = r_perf;
`endif

    // Storage is left unreset; the occupancy counter alone defines valid entries.
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.dma_r_data;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_src         <= '0;
            r_dst         <= '0;
            r_len         <= '0;
            r_rd_cnt      <= '0;
            r_out_cnt     <= '0;
            r_wr_cnt      <= '0;
            r_outstanding <= '0;
            r_fifo_count  <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_w_valid     <= 1'b0;
            r_w_addr      <= '0;
            r_w_data      <= '0;
`ifdef DMA_STREAM_PERF_EN
            r_perf        <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_src     <= cfg_src_addr;
                        r_dst     <= cfg_dst_addr;
                        r_len     <= cfg_len;
                        r_rd_cnt  <= '0;
                        r_out_cnt <= '0;
                        r_wr_cnt  <= '0;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
`ifdef DMA_STREAM_PERF_EN
                        r_perf    <= '0;
`endif
                        if (cfg_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
`ifdef DMA_STREAM_PERF_EN
                    if (r_perf != 32'hFFFF_FFFF) begin
                        r_perf <= r_perf + 32'd1;
                    end
`endif
                    // The final write must have left the port before completion.
                    if ((r_out_cnt == r_len) && (r_wr_cnt == r_len) && !r_w_valid) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase

            if (w_rd_fire) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (w_rd_fire && !w_push) begin
                r_outstanding <= r_outstanding + 1'b1;
            end else if (!w_rd_fire && w_push) begin
                r_outstanding <= r_outstanding - 1'b1;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_out_cnt <= r_out_cnt + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_fifo_count <= r_fifo_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_fifo_count <= r_fifo_count - 1'b1;
            end

            r_w_valid <= w_ss_fire;
            if (w_ss_fire) begin
                r_w_addr <= r_dst + r_wr_cnt;
                r_w_data <= bus.ss_tdata;
                r_wr_cnt <= r_wr_cnt + 1'b1;
                if (bus.ss_tlast != (r_wr_cnt == w_len_m1)) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
